// File: rtl/ft_pkg.sv
// Shared types and constants for the FT601 stream packetizer slice.
// Optional feature macro: PKT_CHECKSUM_EN (adds the XOR trailer dword).
package ft_pkg;

    localparam int DWORD_W = 32;
    localparam int SEQ_W   = 16;

    localparam logic [DWORD_W-SEQ_W-1:0] HDR_MAGIC_DEFAULT = 16'hA55A;

    typedef logic [DWORD_W-1:0] ft_dword_t;

    // TRAILER is only reachable when the checksum trailer is built in
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } pkt_state_t;

    // Header dword: magic in the upper half, packet sequence number below
    function automatic ft_dword_t make_header(input logic [DWORD_W-SEQ_W-1:0] magic,
                                              input logic [SEQ_W-1:0]         seq);
        return {magic, seq};
    endfunction

endpackage

// File: rtl/ft_sfifo.sv
// Synchronous first-word fall-through FIFO, depth 2**DEPTH_LG.
// The head word is read straight from the array so it is valid as soon as
// o_empty drops. Writes while full are refused even if a read happens in
// the same cycle.
module ft_sfifo
    import ft_pkg::*;
#(
    parameter int DEPTH_LG = 4
) (
    input  logic              i_ftdi_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [DWORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DWORD_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [DEPTH_LG:0] o_count
);

    localparam int DEPTH = 1 << DEPTH_LG;

    ft_dword_t               mem [DEPTH];
    logic [DEPTH_LG-1:0]     wr_ptr_reg;
    logic [DEPTH_LG-1:0]     rd_ptr_reg;
    logic [DEPTH_LG:0]       count_reg;
    logic                    wr_accept;
    logic                    rd_accept;

    assign o_full    = (count_reg == (DEPTH_LG + 1)'(DEPTH));
    assign o_empty   = (count_reg == '0);
    assign o_count   = count_reg;
    assign o_rd_data = mem[rd_ptr_reg];

    assign wr_accept = i_wr_en && !o_full;
    assign rd_accept = i_rd_en && !o_empty;

    // Storage array; no reset so it maps onto distributed/block memory
    always_ff @(posedge i_ftdi_clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= i_wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count as is
    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ft_stream_packetizer.sv
// Packet framing ahead of the FT601 bus master: buffers a free-running
// sample stream and emits header + PKT_LEN payload dwords on valid/ready.
// Define PKT_CHECKSUM_EN to append an XOR checksum trailer dword.
module ft_stream_packetizer
    import ft_pkg::*;
#(
    parameter int                        DEPTH_LG  = 4,
    parameter int                        PKT_LEN   = 256,
    parameter logic [DWORD_W-SEQ_W-1:0]  HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic               i_ftdi_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_s_valid,
    input  logic [DWORD_W-1:0] i_s_data,
    output logic               o_m_valid,
    output logic [DWORD_W-1:0] o_m_data,
    output logic               o_m_last,
    input  logic               i_m_ready,
    output logic [SEQ_W-1:0]   o_seq,
    output logic [15:0]        o_drop_count,
    output logic               o_busy
);

    pkt_state_t          state_reg;
    pkt_state_t          state_next;
    logic [15:0]         cnt_reg;
    logic [15:0]         cnt_next;
    logic [SEQ_W-1:0]    seq_reg;
    logic [SEQ_W-1:0]    seq_next;
    logic [15:0]         drop_reg;

    logic [DWORD_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LG:0]   fifo_count;
    logic                fifo_pop;
    logic                handshake;
    logic                last_payload;

`ifdef PKT_CHECKSUM_EN
    logic [DWORD_W-1:0]  csum_reg;
`endif

    ft_sfifo #(
        .DEPTH_LG (DEPTH_LG)
    ) u_fifo (
        .i_ftdi_clk (i_ftdi_clk),
        .i_reset    (i_reset),
        .i_wr_en    (i_s_valid),
        .i_wr_data  (i_s_data),
        .i_rd_en    (fifo_pop),
        .o_rd_data  (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_count    (fifo_count)
    );

    assign handshake    = o_m_valid && i_m_ready;
    assign last_payload = (cnt_reg == 16'(PKT_LEN - 1));
    assign o_seq        = seq_reg;
    assign o_drop_count = drop_reg;
    assign o_busy       = (state_reg != ST_IDLE);

    // State register
    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; enable only matters while idle, so packets always complete
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_enable && (fifo_count != '0)) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (handshake) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (handshake && last_payload) begin
`ifdef PKT_CHECKSUM_EN
                    state_next = ST_TRAILER;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_TRAILER: begin
`ifdef PKT_CHECKSUM_EN
                if (handshake) begin
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from registered state and FIFO head only (ready never gates valid)
    always_comb begin
        o_m_valid = 1'b0;
        o_m_data  = '0;
        o_m_last  = 1'b0;
        fifo_pop  = 1'b0;
        case (state_reg)
            ST_HEADER: begin
                o_m_valid = 1'b1;
                o_m_data  = make_header(HDR_MAGIC, seq_reg);
            end
            ST_PAYLOAD: begin
                o_m_valid = !fifo_empty;
                o_m_data  = fifo_head;
                fifo_pop  = i_m_ready && !fifo_empty;
`ifndef PKT_CHECKSUM_EN
                o_m_last  = last_payload;
`endif
            end
            ST_TRAILER: begin
`ifdef PKT_CHECKSUM_EN
                o_m_valid = 1'b1;
                o_m_data  = csum_reg;
                o_m_last  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Payload position and sequence number bookkeeping
    always_comb begin
        cnt_next = cnt_reg;
        seq_next = seq_reg;
        if (state_reg == ST_HEADER) begin
            cnt_next = '0;
        end else if ((state_reg == ST_PAYLOAD) && handshake) begin
            if (last_payload) begin
                cnt_next = '0;
                seq_next = seq_reg + 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Counters are rewritten every cycle so the sequence number always tracks its next value
    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_reg <= '0;
            seq_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            seq_reg <= seq_next;
        end
    end

    // Saturating count of samples refused because the FIFO was full
    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            drop_reg <= '0;
        end else if (i_s_valid && fifo_full && (drop_reg != 16'hFFFF)) begin
            drop_reg <= drop_reg + 1'b1;
        end
    end

`ifdef PKT_CHECKSUM_EN
    // Running XOR over header and payload, cleared when a packet starts
    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            csum_reg <= '0;
        end else if ((state_reg == ST_IDLE) && (state_next == ST_HEADER)) begin
            csum_reg <= '0;
        end else if (handshake && ((state_reg == ST_HEADER) || (state_reg == ST_PAYLOAD))) begin
            csum_reg <= csum_reg ^ o_m_data;
        end
    end
`endif

endmodule

// File: tb/tb_ft_stream_packetizer.sv
// Scoreboard bench for ft_stream_packetizer (PKT_LEN=4, DEPTH_LG=4).
// Expected dwords are queued as samples are driven and checked on handshake.
module tb_ft_stream_packetizer;

    localparam int          PKT_LEN  = 4;
    localparam int          DEPTH_LG = 4;
    localparam logic [15:0] MAGIC    = 16'hA55A;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_s_valid;
    logic [31:0] i_s_data;
    logic        o_m_valid;
    logic [31:0] o_m_data;
    logic        o_m_last;
    logic        i_m_ready;
    logic [15:0] o_seq;
    logic [15:0] o_drop_count;
    logic        o_busy;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          hs_count     = 0;
    exp_t        exp_q[$];

    logic [15:0] model_seq  = 16'd0;
    int          model_idx  = 0;
    logic [31:0] model_csum = 32'd0;

    logic        stall_reg  = 1'b0;
    logic [31:0] hold_data  = 32'd0;

    ft_stream_packetizer #(
        .DEPTH_LG  (DEPTH_LG),
        .PKT_LEN   (PKT_LEN),
        .HDR_MAGIC (MAGIC)
    ) dut (
        .i_ftdi_clk   (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_s_valid    (i_s_valid),
        .i_s_data     (i_s_data),
        .o_m_valid    (o_m_valid),
        .o_m_data     (o_m_data),
        .o_m_last     (o_m_last),
        .i_m_ready    (i_m_ready),
        .o_seq        (o_seq),
        .o_drop_count (o_drop_count),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    // Build the expected output stream for one accepted sample
    task automatic model_push(input logic [31:0] d);
        exp_t e;
        if (model_idx == 0) begin
            e.data = {MAGIC, model_seq};
            e.last = 1'b0;
            exp_q.push_back(e);
            model_csum = e.data;
        end
        model_csum = model_csum ^ d;
        e.data = d;
`ifdef PKT_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (model_idx == PKT_LEN - 1);
`endif
        exp_q.push_back(e);
        model_idx++;
        if (model_idx == PKT_LEN) begin
`ifdef PKT_CHECKSUM_EN
            e.data = model_csum;
            e.last = 1'b1;
            exp_q.push_back(e);
`endif
            model_seq = model_seq + 16'd1;
            model_idx = 0;
        end
    endtask

    // Drive one sample for one cycle; accepted samples feed the model
    task automatic drive_sample(input logic [31:0] d, input bit accepted);
        i_s_valid = 1'b1;
        i_s_data  = d;
        @(posedge clk);
        #1;
        i_s_valid = 1'b0;
        if (accepted) model_push(d);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !o_busy) break;
            @(posedge clk);
            #1;
        end
        check_eq("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_idle", 64'(o_busy), 64'd0);
    endtask

    // Monitor: sample away from the rising edge; a valid&&ready seen here completes at the next edge
    always @(negedge clk) begin
        exp_t e;
        if (i_reset) begin
            stall_reg = 1'b0;
        end else begin
            if (stall_reg) begin
                check_eq("hold_valid", 64'(o_m_valid), 64'd1);
                check_eq("hold_data", 64'(o_m_data), 64'(hold_data));
            end
            if (o_m_valid && i_m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_dword", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_data", 64'(o_m_data), 64'(e.data));
                    check_eq("sb_last", 64'(o_m_last), 64'(e.last));
                end
                hs_count++;
            end
            stall_reg = o_m_valid && !i_m_ready;
            hold_data = o_m_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int hs0;
        i_reset   = 1'b1;
        i_enable  = 1'b0;
        i_s_valid = 1'b0;
        i_s_data  = 32'd0;
        i_m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(o_m_valid), 64'd0);
        check_eq("rst_last", 64'(o_m_last), 64'd0);
        check_eq("rst_data", 64'(o_m_data), 64'd0);
        check_eq("rst_seq", 64'(o_seq), 64'd0);
        check_eq("rst_drop", 64'(o_drop_count), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        i_reset = 1'b0;
        @(posedge clk);
        #1;

        // Single packet: header A55A0000, 1..4
        i_enable  = 1'b1;
        i_m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) drive_sample(32'(i), 1'b1);
        wait_drain(100);
        check_eq("single_seq", 64'(o_seq), 64'd1);
        check_eq("single_drop", 64'(o_drop_count), 64'd0);

        // Overflow: nothing drains, 20 pushes into 16 entries
        i_enable  = 1'b0;
        i_m_ready = 1'b0;
        for (int i = 1; i <= 20; i++) drive_sample(32'(i), i <= 16);
        check_eq("ovf_drop", 64'(o_drop_count), 64'd4);
        check_eq("ovf_idle_valid", 64'(o_m_valid), 64'd0);
        i_enable  = 1'b1;
        i_m_ready = 1'b1;
        wait_drain(200);
        check_eq("ovf_seq", 64'(o_seq), 64'(model_seq));

        // Underrun: half a packet, the FSM must wait with valid low
        drive_sample(32'h0000_1001, 1'b1);
        drive_sample(32'h0000_1002, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("underrun_busy", 64'(o_busy), 64'd1);
        check_eq("underrun_valid", 64'(o_m_valid), 64'd0);
        drive_sample(32'h0000_1003, 1'b1);
        drive_sample(32'h0000_1004, 1'b1);
        wait_drain(100);

        // Random ready with sparse samples, 10 packets worth
        sent = 0;
        while (sent < 40) begin
            i_m_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) begin
                drive_sample($urandom, 1'b1);
                sent++;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        i_m_ready = 1'b1;
        wait_drain(500);
        check_eq("rand_drop", 64'(o_drop_count), 64'd4);
        check_eq("rand_seq", 64'(o_seq), 64'(model_seq));

        // Sequence wrap: preload FFFF while idle
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        force dut.seq_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_reg;
        @(posedge clk);
        #1;
        check_eq("wrap_preload", 64'(o_seq), 64'hFFFF);
        model_seq = 16'hFFFF;
        i_enable  = 1'b1;
        for (int i = 1; i <= 4; i++) drive_sample(32'(32'h2000 + i), 1'b1);
        wait_drain(100);
        check_eq("wrap_seq", 64'(o_seq), 64'd0);

        // Reset after header and two payload dwords
        i_enable  = 1'b0;
        i_m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive_sample(32'(32'h3000 + i), 1'b1);
        hs0 = hs_count;
        i_enable  = 1'b1;
        i_m_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (hs_count >= hs0 + 3) break;
            @(negedge clk);
        end
        check_eq("rstmid_reached", 64'(hs_count - hs0), 64'd3);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        #1;
        exp_q.delete();
        model_seq  = 16'd0;
        model_idx  = 0;
        model_csum = 32'd0;
        check_eq("rstmid_valid", 64'(o_m_valid), 64'd0);
        check_eq("rstmid_last", 64'(o_m_last), 64'd0);
        check_eq("rstmid_data", 64'(o_m_data), 64'd0);
        check_eq("rstmid_seq", 64'(o_seq), 64'd0);
        check_eq("rstmid_drop", 64'(o_drop_count), 64'd0);
        check_eq("rstmid_busy", 64'(o_busy), 64'd0);
        check_eq("rstmid_fifo_empty", 64'(dut.u_fifo.o_empty), 64'd1);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) drive_sample(32'(32'h4000 + i), 1'b1);
        wait_drain(100);
        check_eq("post_rst_seq", 64'(o_seq), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
